// File: rtl/sw_event_reader.sv
// Autonomous Avalon-MM initiator for an edge-capture switch PIO: services each
// PIO interrupt and turns it into a {edges, levels} event word in a FWFT FIFO.
module sw_event_reader #(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] IRQ_MASK   = {WIDTH{1'b1}},
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             irq,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [WIDTH-1:0] ev_edges,
  output logic [WIDTH-1:0] ev_levels,
  output logic [7:0]       drop_count,
  output logic             busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CAP_A, S_CAP_D, S_CLR, S_LVL_A, S_LVL_D, S_PUSH
  } state_t;

  state_t state, state_next;

  logic [1:0]       address_next;
  logic             chipselect_next;
  logic             write_n_next;
  logic [31:0]      writedata_next;
  logic [WIDTH-1:0] edges_lat;
  logic [WIDTH-1:0] levels_lat;

  logic [2*WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0]      count, count_next, count_after_pop;
  logic               pop, push_req, full, push_ok, drop;
  logic [2*WIDTH-1:0] push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // INIT lingers until its own write strobe has been on the bus for one cycle
  always_comb begin
    state_next = state;
    case (state)
      S_INIT:  if (avm_chipselect) state_next = S_IDLE;
      S_IDLE:  if (irq) state_next = S_CAP_A;
      S_CAP_A: state_next = S_CAP_D;
      S_CAP_D: state_next = S_CLR;
      S_CLR:   state_next = S_LVL_A;
      S_LVL_A: state_next = S_LVL_D;
      S_LVL_D: state_next = S_PUSH;
      S_PUSH:  state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  // Bus strobes are registered from the state being entered
  always_comb begin
    address_next    = avm_address;
    chipselect_next = 1'b0;
    write_n_next    = 1'b1;
    writedata_next  = avm_writedata;
    case (state_next)
      S_INIT: begin
        address_next    = ADDR_MASK;
        chipselect_next = 1'b1;
        write_n_next    = 1'b0;
        writedata_next  = 32'(IRQ_MASK);
      end
      S_CAP_A: begin
        address_next    = ADDR_EDGE;
        chipselect_next = 1'b1;
      end
      S_CLR: begin
        address_next    = ADDR_EDGE;
        chipselect_next = 1'b1;
        write_n_next    = 1'b0;
        writedata_next  = 32'd0;
      end
      S_LVL_A: begin
        address_next    = ADDR_DATA;
        chipselect_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avm_address    <= 2'd0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_writedata  <= 32'd0;
    end else begin
      avm_address    <= address_next;
      avm_chipselect <= chipselect_next;
      avm_write_n    <= write_n_next;
      avm_writedata  <= writedata_next;
    end
  end

  // readdata arrives one cycle after the address phase
  always_ff @(posedge clk) begin
    if (state == S_CAP_D) edges_lat  <= avm_readdata[WIDTH-1:0];
    if (state == S_LVL_D) levels_lat <= avm_readdata[WIDTH-1:0];
  end

  assign busy            = (state != S_IDLE);
  assign push_data       = {edges_lat, levels_lat};
  assign pop             = ev_valid && ev_ready;
  assign push_req        = (state == S_PUSH);
  assign full            = (count == CW'(FIFO_DEPTH));
  assign push_ok         = push_req && (!full || pop);
  assign drop            = push_req && full && !pop;
  assign count_after_pop = count - CW'(pop);
  assign count_next      = count_after_pop + CW'(push_ok);
  assign rd_next         = rd_ptr + AW'(pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Head register: a push into an empty FIFO bypasses the storage array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ev_valid   <= 1'b0;
      ev_edges   <= '0;
      ev_levels  <= '0;
      drop_count <= 8'd0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        ev_valid <= 1'b1;
        if (push_ok && count_after_pop == '0) {ev_edges, ev_levels} <= push_data;
        else                                  {ev_edges, ev_levels} <= mem[rd_next];
      end else begin
        ev_valid <= 1'b0;
      end
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule
